// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - two-requester round-robin arbiter for the PicoRV native memory bus
// Serialises m0/m1 onto one downstream port, holds each grant to completion, aborts hung transfers.
module picorv32_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter int unsigned CNT_WDT        = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic        grant_id,
  output logic        timeout_flag,
  output logic        timeout_id,
  input  logic        timeout_clr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam bit                 WDT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WDT-1:0] WDT_LAST = CNT_WDT'(TIMEOUT_CYCLES - 1);

  state_t             state, state_nx;
  logic               last_grant;
  logic [CNT_WDT-1:0] counter;
  logic               any_valid, winner, wdt_hit, fire;
  logic [31:0]        fire_data;

  // On a tie the requester that did not own the previous transfer wins.
  always_comb begin
    any_valid = m0_mem_valid | m1_mem_valid;
    winner    = m1_mem_valid & (~m0_mem_valid | ~last_grant);
    wdt_hit   = WDT_EN && (counter == WDT_LAST) && !s_mem_ready;
    fire      = (state == BUSY) && (s_mem_ready || wdt_hit);
    fire_data = s_mem_ready ? s_mem_rdata : ERR_RDATA;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_valid) state_nx = BUSY;
      BUSY:    if (fire)      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant   <= 1'b1;
      counter      <= '0;
      grant_id     <= 1'b0;
      s_mem_valid  <= 1'b0;
      s_mem_instr  <= 1'b0;
      s_mem_addr   <= '0;
      s_mem_wdata  <= '0;
      s_mem_wstrb  <= '0;
      m0_mem_ready <= 1'b0;
      m1_mem_ready <= 1'b0;
      m0_mem_rdata <= '0;
      m1_mem_rdata <= '0;
      timeout_flag <= 1'b0;
      timeout_id   <= 1'b0;
    end else begin
      // Ready pulses and their data live for the single DONE cycle only.
      m0_mem_ready <= fire && !grant_id;
      m1_mem_ready <= fire && grant_id;
      m0_mem_rdata <= (fire && !grant_id) ? fire_data : '0;
      m1_mem_rdata <= (fire && grant_id) ? fire_data : '0;
      if (timeout_clr) timeout_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            s_mem_valid <= 1'b1;
            s_mem_instr <= winner ? m1_mem_instr : m0_mem_instr;
            s_mem_addr  <= winner ? m1_mem_addr  : m0_mem_addr;
            s_mem_wdata <= winner ? m1_mem_wdata : m0_mem_wdata;
            s_mem_wstrb <= winner ? m1_mem_wstrb : m0_mem_wstrb;
            grant_id    <= winner;
            last_grant  <= winner;
            counter     <= '0;
          end
        end
        BUSY: begin
          if (fire) begin
            s_mem_valid <= 1'b0;
            if (!s_mem_ready) begin
              timeout_flag <= 1'b1;
              timeout_id   <= grant_id;
            end
          end else begin
            counter <= counter + CNT_WDT'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb/tb_picorv32_mem_arbiter.sv - directed self-checking bench for picorv32_mem_arbiter
module tb_picorv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_mem_valid, m0_mem_instr, m1_mem_valid, m1_mem_instr;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m1_mem_addr, m1_mem_wdata;
  logic [3:0]  m0_mem_wstrb, m1_mem_wstrb;
  logic        m0_mem_ready, m1_mem_ready;
  logic [31:0] m0_mem_rdata, m1_mem_rdata;
  logic        s_mem_valid, s_mem_instr, s_mem_ready;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [3:0]  s_mem_wstrb;
  logic        grant_id, timeout_flag, timeout_id, timeout_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  picorv32_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready),
    .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready),
    .m1_mem_rdata(m1_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb), .s_mem_ready(s_mem_ready),
    .s_mem_rdata(s_mem_rdata),
    .grant_id(grant_id), .timeout_flag(timeout_flag), .timeout_id(timeout_id),
    .timeout_clr(timeout_clr)
  );

  wire [138:0] all_out = {s_mem_valid, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb,
                          m0_mem_ready, m1_mem_ready, m0_mem_rdata, m1_mem_rdata,
                          grant_id, timeout_flag, timeout_id};

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    m0_mem_valid = 0; m0_mem_instr = 0; m0_mem_addr = 0; m0_mem_wdata = 0; m0_mem_wstrb = 0;
    m1_mem_valid = 0; m1_mem_instr = 0; m1_mem_addr = 0; m1_mem_wdata = 0; m1_mem_wstrb = 0;
    s_mem_ready = 0; s_mem_rdata = 0; timeout_clr = 0;
    step; step;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", all_out);
    end
    resetn = 1'b1;
    step;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL idle_after_reset got %h expected 0", all_out);
    end
  endtask

  task automatic test_m0_read;
    m0_mem_valid = 1; m0_mem_addr = 32'h4000_0010; m0_mem_wstrb = 4'h0;
    step;
    checks++;
    if ({s_mem_valid, s_mem_addr, s_mem_wstrb, grant_id} !== {1'b1, 32'h4000_0010, 4'h0, 1'b0}) begin
      errors++; $display("FAIL m0_read_issue got %b %h %h %b expected 1 40000010 0 0",
                         s_mem_valid, s_mem_addr, s_mem_wstrb, grant_id);
    end
    step;
    step;
    checks++;
    if ({s_mem_valid, m0_mem_ready} !== 2'b10) begin
      errors++; $display("FAIL m0_read_wait got valid=%b ready=%b expected 1 0", s_mem_valid, m0_mem_ready);
    end
    s_mem_ready = 1; s_mem_rdata = 32'h1234_5678;
    step;
    s_mem_ready = 0; m0_mem_valid = 0;
    checks++;
    if ({m0_mem_ready, m0_mem_rdata, m1_mem_ready, m1_mem_rdata, s_mem_valid} !==
        {1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL m0_read_done got r0=%b d0=%h r1=%b d1=%h sv=%b expected 1 12345678 0 0 0",
                         m0_mem_ready, m0_mem_rdata, m1_mem_ready, m1_mem_rdata, s_mem_valid);
    end
    step;
    checks++;
    if ({m0_mem_ready, m0_mem_rdata} !== 33'h0) begin
      errors++; $display("FAIL m0_read_pulse got ready=%b rdata=%h expected 0 0", m0_mem_ready, m0_mem_rdata);
    end
  endtask

  task automatic test_round_robin;
    logic exp;
    m0_mem_valid = 1; m0_mem_addr = 32'h0000_0100; m0_mem_wstrb = 0;
    m1_mem_valid = 1; m1_mem_addr = 32'h0000_0200; m1_mem_wstrb = 0;
    s_mem_ready = 1; s_mem_rdata = 32'hCAFE_0000;
    for (int i = 0; i < 6; i++) begin
      exp = i[0];
      step;
      checks++;
      if ({s_mem_valid, grant_id, s_mem_addr} !== {1'b1, exp, exp ? 32'h200 : 32'h100}) begin
        errors++; $display("FAIL rr_grant[%0d] got valid=%b id=%b addr=%h expected id=%b", i,
                           s_mem_valid, grant_id, s_mem_addr, exp);
      end
      step;
      checks++;
      if ({m0_mem_ready, m1_mem_ready, m0_mem_rdata | m1_mem_rdata} !== {~exp, exp, 32'hCAFE_0000}) begin
        errors++; $display("FAIL rr_ready[%0d] got r0=%b r1=%b expected r0=%b r1=%b", i,
                           m0_mem_ready, m1_mem_ready, ~exp, exp);
      end
      step;
    end
    m0_mem_valid = 0; m1_mem_valid = 0; s_mem_ready = 0;
    step;
  endtask

  task automatic test_m1_write;
    m1_mem_valid = 1; m1_mem_instr = 0; m1_mem_addr = 32'h4000_0100;
    m1_mem_wdata = 32'hA5A5_0000; m1_mem_wstrb = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if ({s_mem_valid, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb, grant_id} !==
          {1'b1, 1'b0, 32'h4000_0100, 32'hA5A5_0000, 4'b1100, 1'b1}) begin
        errors++; $display("FAIL m1_write_busy[%0d] got %b %h %h %b id=%b", i,
                           s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb, grant_id);
      end
    end
    s_mem_ready = 1;
    step;
    s_mem_ready = 0; m1_mem_valid = 0;
    checks++;
    if ({m1_mem_ready, m0_mem_ready} !== 2'b10) begin
      errors++; $display("FAIL m1_write_done got r1=%b r0=%b expected 1 0", m1_mem_ready, m0_mem_ready);
    end
    step;
    checks++;
    if (m1_mem_ready !== 1'b0) begin
      errors++; $display("FAIL m1_write_pulse got %b expected 0", m1_mem_ready);
    end
  endtask

  task automatic test_timeout;
    m0_mem_valid = 1; m0_mem_addr = 32'h4000_0020; m0_mem_wstrb = 0;
    for (int i = 0; i < 8; i++) begin
      step;
      checks++;
      if (s_mem_valid !== 1'b1) begin
        errors++; $display("FAIL wdt_busy[%0d] got s_mem_valid=%b expected 1", i, s_mem_valid);
      end
    end
    step;
    m0_mem_valid = 0;
    checks++;
    if ({s_mem_valid, m0_mem_ready, m0_mem_rdata, timeout_flag, timeout_id} !==
        {1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wdt_abort got sv=%b r0=%b d0=%h flag=%b id=%b expected 0 1 deadbeef 1 0",
                         s_mem_valid, m0_mem_ready, m0_mem_rdata, timeout_flag, timeout_id);
    end
    step;
    checks++;
    if (timeout_flag !== 1'b1) begin
      errors++; $display("FAIL wdt_sticky got %b expected 1", timeout_flag);
    end
    timeout_clr = 1;
    step;
    timeout_clr = 0;
    checks++;
    if (timeout_flag !== 1'b0) begin
      errors++; $display("FAIL wdt_clear got %b expected 0", timeout_flag);
    end
  endtask

  task automatic test_timeout_edge;
    m0_mem_valid = 1; m0_mem_addr = 32'h4000_0030; m0_mem_wstrb = 0;
    for (int i = 0; i < 8; i++) step;
    s_mem_ready = 1; s_mem_rdata = 32'h600D_F00D;
    step;
    s_mem_ready = 0; m0_mem_valid = 0;
    checks++;
    if ({m0_mem_ready, m0_mem_rdata, timeout_flag} !== {1'b1, 32'h600D_F00D, 1'b0}) begin
      errors++; $display("FAIL wdt_edge got r0=%b d0=%h flag=%b expected 1 600df00d 0",
                         m0_mem_ready, m0_mem_rdata, timeout_flag);
    end
    step;
  endtask

  task automatic test_reset_busy;
    m0_mem_valid = 1; m0_mem_addr = 32'h4000_0040; m0_mem_wstrb = 0;
    step;
    checks++;
    if (s_mem_valid !== 1'b1) begin
      errors++; $display("FAIL rst_busy_pre got %b expected 1", s_mem_valid);
    end
    resetn = 0; s_mem_ready = 1; s_mem_rdata = 32'h1111_2222;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL rst_async got %h expected 0", all_out);
    end
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if (all_out !== '0) begin
        errors++; $display("FAIL rst_hold[%0d] got %h expected 0", i, all_out);
      end
    end
    resetn = 1; s_mem_ready = 0;
    step;
    checks++;
    if ({s_mem_valid, s_mem_addr, grant_id, m0_mem_ready} !== {1'b1, 32'h4000_0040, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_regrant got sv=%b addr=%h id=%b r0=%b expected 1 40000040 0 0",
                         s_mem_valid, s_mem_addr, grant_id, m0_mem_ready);
    end
    s_mem_ready = 1; s_mem_rdata = 32'h3333_4444;
    step;
    s_mem_ready = 0; m0_mem_valid = 0;
    checks++;
    if ({m0_mem_ready, m0_mem_rdata} !== {1'b1, 32'h3333_4444}) begin
      errors++; $display("FAIL rst_after_done got r0=%b d0=%h expected 1 33334444",
                         m0_mem_ready, m0_mem_rdata);
    end
    step;
  endtask

  initial begin
    test_reset;
    test_m0_read;
    test_reset;
    test_round_robin;
    test_m1_write;
    test_timeout;
    test_timeout_edge;
    test_reset_busy;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
